cache_refill_ctrl: RTL and testbench

Sequencing controller for the set-associative read cache. Accepts word-address read requests, drives tag/data SRAM reads, and consumes the hit/data result of the way-select datapath. On a miss it picks a victim way, bursts the line in from memory, writes data and tag SRAMs, and returns the requested word. It also owns reset-time and flush-time tag invalidation.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/cache_victim_sel.sv | 37 +++
 rtl/cache_refill_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the read-cache refill controller: state encoding,
// tag word layout and the default geometry the derived widths come from.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_LOOKUP    = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_DATA = 3'd4,
    S_TAG_WR    = 3'd5,
    S_RESP      = 3'd6
  } state_e;

  localparam int TAG_VALID_BIT        = 31;
  localparam int DEF_ADDR_WIDTH       = 32;
  localparam int DEF_CLINE_SIZE_WORD  = 4;
  localparam int DEF_CLINE_ADDR_WIDTH = 7;
  localparam int OFFW      = $clog2(DEF_CLINE_SIZE_WORD);
  localparam int TAG_WIDTH = DEF_ADDR_WIDTH - OFFW - DEF_CLINE_ADDR_WIDTH;

  // A single-way cache still needs a one-bit way index.
  function automatic int way_idx_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: first invalid way wins, otherwise a round-robin
// pointer that steps once per completed tag write.
module cache_victim_sel
  import cache_ctrl_pkg::*;
#(
  parameter  int NUM_WAYS = 2,
  localparam int WAY_W    = way_idx_width(NUM_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_WAYS-1:0] tag_valid_i,
  input  logic                advance_i,
  output logic [WAY_W-1:0]    victim_o
);

  logic [WAY_W-1:0] rr_ptr_r;

  // Descending scan so the lowest-index invalid way overrides the others.
  always_comb begin
    victim_o = rr_ptr_r;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      victim_o = tag_valid_i[i] ? victim_o : WAY_W'(i);
    end
  end

  // Round-robin pointer, wraps at NUM_WAYS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= '0;
    end else if (advance_i) begin
      rr_ptr_r <= (rr_ptr_r == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_ptr_r + WAY_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Set-associative read cache sequencer: lookup, miss refill from memory,
// tag/data SRAM writes, and reset/flush-time tag invalidation.
module cache_refill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS            = 2,
  parameter int ADDR_WIDTH          = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH          = 32,
  parameter int CLINE_SIZE_WORD     = DEF_CLINE_SIZE_WORD,
  parameter int CLINE_ADDR_WIDTH    = DEF_CLINE_ADDR_WIDTH,
  parameter int TAG_SRAM_DATA_WIDTH = 32
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            flush_i,
  input  logic                                            req_valid_i,
  output logic                                            req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                           req_addr_i,
  output logic                                            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                           rsp_data_o,
  input  logic                                            hit_i,
  input  logic [NUM_WAYS-1:0]                             way_hit_i,
  input  logic [DATA_WIDTH-1:0]                           hit_data_i,
  input  logic [NUM_WAYS-1:0]                             tag_valid_i,
  output logic [CLINE_ADDR_WIDTH-1:0]                     tag_addr_o,
  output logic [NUM_WAYS-1:0]                             tag_we_o,
  output logic [TAG_SRAM_DATA_WIDTH-1:0]                  tag_wdata_o,
  output logic [CLINE_ADDR_WIDTH+$clog2(CLINE_SIZE_WORD)-1:0] data_addr_o,
  output logic [NUM_WAYS-1:0]                             data_we_o,
  output logic [DATA_WIDTH-1:0]                           data_wdata_o,
  output logic                                            mem_req_valid_o,
  input  logic                                            mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                           mem_addr_o,
  input  logic                                            mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                           mem_rdata_i
);

  localparam int OFF_W = $clog2(CLINE_SIZE_WORD);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - CLINE_ADDR_WIDTH;
  localparam int WAY_W = way_idx_width(NUM_WAYS);

  localparam logic [2:0] ST_INIT      = S_INIT;
  localparam logic [2:0] ST_IDLE      = S_IDLE;
  localparam logic [2:0] ST_LOOKUP    = S_LOOKUP;
  localparam logic [2:0] ST_FILL_REQ  = S_FILL_REQ;
  localparam logic [2:0] ST_FILL_DATA = S_FILL_DATA;
  localparam logic [2:0] ST_TAG_WR    = S_TAG_WR;
  localparam logic [2:0] ST_RESP      = S_RESP;

  logic [2:0]                     state_r, state_nxt_s;
  logic                           run_r;
  logic [CLINE_ADDR_WIDTH-1:0]    idx_r;
  logic [OFF_W-1:0]               beat_r;
  logic [ADDR_WIDTH-1:0]          addr_r;
  logic [WAY_W-1:0]               victim_r, victim_s;
  logic [DATA_WIDTH-1:0]          rsp_r;
  logic                           pend_r;
  logic                           accept_s, advance_s, flush_take_s, hit_s;
  logic [NUM_WAYS-1:0]            way_mask_s;
  logic [TAG_SRAM_DATA_WIDTH-1:0] tag_word_s;

  logic [CLINE_ADDR_WIDTH-1:0] req_idx_s, lat_idx_s;
  logic [OFF_W-1:0]            req_off_s, lat_off_s;
  logic [TAG_W-1:0]            lat_tag_s;

  assign req_off_s  = req_addr_i[0 +: OFF_W];
  assign req_idx_s  = req_addr_i[OFF_W +: CLINE_ADDR_WIDTH];
  assign lat_off_s  = addr_r[0 +: OFF_W];
  assign lat_idx_s  = addr_r[OFF_W +: CLINE_ADDR_WIDTH];
  assign lat_tag_s  = addr_r[ADDR_WIDTH-1 -: TAG_W];
  // Either hit indication from the way-select datapath counts as a hit.
  assign hit_s      = hit_i | (|way_hit_i);
  assign way_mask_s = NUM_WAYS'(1'b1) << victim_r;

  cache_victim_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_sel (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tag_valid_i (tag_valid_i),
    .advance_i   (advance_s),
    .victim_o    (victim_s)
  );

  // Tag word for a refilled line: valid bit plus the line tag.
  always_comb begin
    tag_word_s                = '0;
    tag_word_s[TAG_W-1:0]     = lat_tag_s;
    tag_word_s[TAG_VALID_BIT] = 1'b1;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt_s     = state_r;
    accept_s        = 1'b0;
    advance_s       = 1'b0;
    flush_take_s    = 1'b0;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    rsp_data_o      = '0;
    tag_addr_o      = '0;
    tag_we_o        = '0;
    tag_wdata_o     = '0;
    data_addr_o     = '0;
    data_we_o       = '0;
    data_wdata_o    = '0;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = '0;
    case (state_r)
      ST_INIT: begin
        tag_addr_o = idx_r;
        // Sweep starts on the first clock after reset release.
        if (run_r) begin
          tag_we_o    = '1;
          state_nxt_s = (idx_r == '1) ? ST_IDLE : ST_INIT;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        tag_addr_o  = req_idx_s;
        data_addr_o = {req_idx_s, req_off_s};
        if (flush_i || pend_r) begin
          flush_take_s = 1'b1;
          state_nxt_s  = ST_INIT;
        end else begin
          req_ready_o = 1'b1;
          accept_s    = req_valid_i;
          state_nxt_s = req_valid_i ? ST_LOOKUP : ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        tag_addr_o  = lat_idx_s;
        data_addr_o = {lat_idx_s, lat_off_s};
        if (hit_s) begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = hit_data_i;
          if (flush_i || pend_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            // Back-to-back accept: SRAM addresses move on to the next request.
            req_ready_o = 1'b1;
            accept_s    = req_valid_i;
            tag_addr_o  = req_idx_s;
            data_addr_o = {req_idx_s, req_off_s};
            state_nxt_s = req_valid_i ? ST_LOOKUP : ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {lat_tag_s, lat_idx_s, {OFF_W{1'b0}}};
        state_nxt_s     = mem_req_ready_i ? ST_FILL_DATA : ST_FILL_REQ;
      end
      ST_FILL_DATA: begin
        tag_addr_o   = lat_idx_s;
        data_addr_o  = {lat_idx_s, beat_r};
        data_wdata_o = mem_rdata_i;
        if (mem_rvalid_i) begin
          data_we_o   = way_mask_s;
          state_nxt_s = (beat_r == OFF_W'(CLINE_SIZE_WORD - 1)) ? ST_TAG_WR : ST_FILL_DATA;
        end else begin
          state_nxt_s = ST_FILL_DATA;
        end
      end
      ST_TAG_WR: begin
        tag_addr_o  = lat_idx_s;
        tag_we_o    = way_mask_s;
        tag_wdata_o = tag_word_s;
        advance_s   = 1'b1;
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = rsp_r;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Controller state, counters and latched request context.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_INIT;
      run_r    <= 1'b0;
      idx_r    <= '0;
      beat_r   <= '0;
      addr_r   <= '0;
      victim_r <= '0;
      rsp_r    <= '0;
      pend_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
      idx_r   <= (state_r == ST_INIT && run_r) ? idx_r + CLINE_ADDR_WIDTH'(1) : idx_r;
      addr_r  <= accept_s ? req_addr_i : addr_r;
      victim_r <= (state_r == ST_LOOKUP && !hit_s) ? victim_s : victim_r;
      if (state_r == ST_FILL_REQ) begin
        beat_r <= '0;
      end else if (state_r == ST_FILL_DATA && mem_rvalid_i) begin
        beat_r <= beat_r + OFF_W'(1);
      end else begin
        beat_r <= beat_r;
      end
      if (state_r == ST_FILL_DATA && mem_rvalid_i && beat_r == lat_off_s) begin
        rsp_r <= mem_rdata_i;
      end else begin
        rsp_r <= rsp_r;
      end
      // A flush seen outside IDLE waits until the controller is idle again.
      if (flush_take_s) begin
        pend_r <= 1'b0;
      end else if (flush_i) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed reads with hand-computed
// expectations queued at issue time and checked by an output monitor.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        hit_i;
  logic [1:0]  way_hit_i;
  logic [31:0] hit_data_i;
  logic [1:0]  tag_valid_i;
  logic [6:0]  tag_addr_o;
  logic [1:0]  tag_we_o;
  logic [31:0] tag_wdata_o;
  logic [8:0]  data_addr_o;
  logic [1:0]  data_we_o;
  logic [31:0] data_wdata_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .hit_i           (hit_i),
    .way_hit_i       (way_hit_i),
    .hit_data_i      (hit_data_i),
    .tag_valid_i     (tag_valid_i),
    .tag_addr_o      (tag_addr_o),
    .tag_we_o        (tag_we_o),
    .tag_wdata_o     (tag_wdata_o),
    .data_addr_o     (data_addr_o),
    .data_we_o       (data_we_o),
    .data_wdata_o    (data_wdata_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  tv;
    logic [1:0]  way;
    logic [31:0] mem;
    logic [8:0]  dbase;
    logic [6:0]  idx;
    logic [31:0] tagw;
    logic [1:0]  off;
    bit          flush;
  } miss_t;

  miss_t       vt [7];
  logic [63:0] rsp_q [$];
  logic [63:0] tag_q [$];
  logic [63:0] dwr_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h with nothing expected", name, act);
  endtask

  // Monitor: every response and SRAM write must match the head of its queue.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (rsp_valid_o) begin
          if (rsp_q.size() == 0) unexpected("rsp", {32'h0, rsp_data_o});
          else begin e = rsp_q.pop_front(); check("rsp_data", {32'h0, rsp_data_o}, e); end
        end
        if (tag_we_o != 2'b00) begin
          if (tag_q.size() == 0) unexpected("tag_wr", {23'h0, tag_we_o, tag_addr_o, tag_wdata_o});
          else begin e = tag_q.pop_front(); check("tag_wr", {23'h0, tag_we_o, tag_addr_o, tag_wdata_o}, e); end
        end
        if (data_we_o != 2'b00) begin
          if (dwr_q.size() == 0) unexpected("data_wr", {21'h0, data_we_o, data_addr_o, data_wdata_o});
          else begin e = dwr_q.pop_front(); check("data_wr", {21'h0, data_we_o, data_addr_o, data_wdata_o}, e); end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_sweep();
    for (int i = 0; i < 128; i++) tag_q.push_back({23'h0, 2'b11, 7'(i), 32'h0});
  endtask

  // Called at a negedge: ready stays low, then a 128-cycle sweep, then ready.
  task automatic expect_sweep();
    int n = 0;
    int hi = 0;
    int k = 0;
    while (tag_we_o == 2'b00 && n < 8) begin
      if (req_ready_o) hi++;
      @(negedge clk);
      n++;
    end
    check("sweep_start", {63'h0, (n < 8)}, 64'h1);
    check("ready_before_sweep", 64'(hi), 64'h0);
    while (!req_ready_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("sweep_ready_low_cycles", 64'(k), 64'd128);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait_bound", {63'h0, (n < 300)}, 64'h1);
  endtask

  task automatic do_miss(input int k);
    miss_t       v;
    logic [31:0] base;
    int          n;
    v    = vt[k];
    base = 32'hC0DE_0000 + 32'(k) * 32'h100;
    wait_ready();
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    hit_i       = 1'b0;
    tag_valid_i = v.tv;
    for (int b = 0; b < 4; b++) dwr_q.push_back({21'h0, v.way, v.dbase + 9'(b), base + 32'(b)});
    tag_q.push_back({23'h0, v.way, v.idx, v.tagw});
    rsp_q.push_back({32'h0, base + 32'(v.off)});
    if (v.flush) push_sweep();
    @(posedge clk); #1;
    tag_valid_i  = 2'b00;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mem_req_valid", {63'h0, mem_req_valid_o}, 64'h1);
    check("mem_addr", {32'h0, mem_addr_o}, {32'h0, v.mem});
    @(posedge clk); #1;
    mem_rvalid_i    = 1'b0;
    mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + 32'(b);
      flush_i      = v.flush && (b == 2);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      flush_i      = 1'b0;
      if (b == 1) begin
        @(posedge clk); #1;
      end
    end
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("miss_rsp_latency", 64'(n), 64'd1);
    if (v.flush) begin
      @(negedge clk);
      expect_sweep();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
    wait_ready();
    req_valid_i = 1'b1;
    req_addr_i  = a;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    hit_i       = 1'b1;
    hit_data_i  = d;
    rsp_q.push_back({32'h0, d});
    @(negedge clk);
    check("hit_rsp_next_cycle", {63'h0, rsp_valid_o}, 64'h1);
    check("hit_no_mem_req", {63'h0, mem_req_valid_o}, 64'h0);
    @(posedge clk); #1;
    hit_i = 1'b0;
    @(negedge clk);
    check("hit_back_to_idle", {62'h0, req_ready_o, mem_req_valid_o}, 64'h2);
    @(posedge clk); #1;
  endtask

  task automatic do_b2b();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs[0] = 32'h0000_1235; addrs[1] = 32'h0000_0434; addrs[2] = 32'h0000_2000;
    datas[0] = 32'hB2B0_0001; datas[1] = 32'hB2B0_0002; datas[2] = 32'hB2B0_0003;
    wait_ready();
    req_valid_i = 1'b1;
    req_addr_i  = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid_i = (i < 2);
      req_addr_i  = (i < 2) ? addrs[i+1] : 32'h0;
      hit_i       = 1'b1;
      hit_data_i  = datas[i];
      rsp_q.push_back({32'h0, datas[i]});
      @(negedge clk);
      check("b2b_ready_rsp", {62'h0, req_ready_o, rsp_valid_o}, 64'h3);
    end
    @(posedge clk); #1;
    hit_i = 1'b0;
  endtask

  initial begin : stim
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0;
    hit_i = 1'b0; way_hit_i = 2'b00; hit_data_i = 32'h0; tag_valid_i = 2'b00;
    mem_req_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    vt[0] = '{addr:32'h0000_1235, tv:2'b00, way:2'b01, mem:32'h0000_1234, dbase:9'h034, idx:7'h0D, tagw:32'h8000_0009, off:2'd1, flush:1'b0};
    vt[1] = '{addr:32'h0000_ABCC, tv:2'b01, way:2'b10, mem:32'h0000_ABCC, dbase:9'h1CC, idx:7'h73, tagw:32'h8000_0055, off:2'd0, flush:1'b0};
    vt[2] = '{addr:32'h0001_0002, tv:2'b11, way:2'b01, mem:32'h0001_0000, dbase:9'h000, idx:7'h00, tagw:32'h8000_0080, off:2'd2, flush:1'b1};
    vt[3] = '{addr:32'h0000_0FFF, tv:2'b10, way:2'b01, mem:32'h0000_0FFC, dbase:9'h1FC, idx:7'h7F, tagw:32'h8000_0007, off:2'd3, flush:1'b0};
    vt[4] = '{addr:32'h0000_0435, tv:2'b11, way:2'b01, mem:32'h0000_0434, dbase:9'h034, idx:7'h0D, tagw:32'h8000_0002, off:2'd1, flush:1'b0};
    vt[5] = '{addr:32'h0000_0636, tv:2'b11, way:2'b10, mem:32'h0000_0634, dbase:9'h034, idx:7'h0D, tagw:32'h8000_0003, off:2'd2, flush:1'b0};
    vt[6] = '{addr:32'h0000_0837, tv:2'b11, way:2'b01, mem:32'h0000_0834, dbase:9'h034, idx:7'h0D, tagw:32'h8000_0004, off:2'd3, flush:1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero",
          {63'h0, |{req_ready_o, rsp_valid_o, rsp_data_o, tag_addr_o, tag_we_o, tag_wdata_o,
                    data_addr_o, data_we_o, data_wdata_o, mem_req_valid_o, mem_addr_o}}, 64'h0);
    push_sweep();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    expect_sweep();
    @(posedge clk); #1;

    do_miss(0);
    do_hit(32'h0000_1235, 32'h600D_1235);
    do_b2b();
    for (int k = 1; k < 7; k++) do_miss(k);

    repeat (5) @(posedge clk);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    check("tag_queue_drained", 64'(tag_q.size()), 64'h0);
    check("data_queue_drained", 64'(dwr_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
